// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD timer.
//  timer_state_t : controller states
//  digit widths, BCD maximum digit values, preset field offsets
//  sat_lo / sat_hi : clamp a raw 4-bit preset digit into its legal range
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

   localparam int LO_W       = 4;
   localparam int HI_W       = 3;
   localparam int BCD_LO_MAX = 9;
   localparam int BCD_HI_MAX = 5;

   localparam int SEC_LO_OFS = 0;
   localparam int SEC_HI_OFS = 4;
   localparam int MIN_LO_OFS = 8;
   localparam int MIN_HI_OFS = 12;
   localparam int HR_LO_OFS  = 16;
   localparam int HR_HI_OFS  = 20;

   function automatic logic [LO_W-1:0] sat_lo(input logic [3:0] d);
      return (d > 4'(BCD_LO_MAX)) ? LO_W'(BCD_LO_MAX) : d;
   endfunction

   function automatic logic [HI_W-1:0] sat_hi(input logic [3:0] d);
      return (d > 4'(BCD_HI_MAX)) ? HI_W'(BCD_HI_MAX) : d[HI_W-1:0];
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit, counting up or down over 0..p_max.
//  i_clk, i_reset   : clock, async active-high reset
//  i_en             : advance one step this cycle
//  i_up             : 1 = count up, 0 = count down
//  i_load/i_load_val: synchronous load (has priority over i_en)
//  o_val            : current digit value
//  o_wrap           : combinational; the next enabled step wraps (carry/borrow)
module bcd_digit_counter
   import timer_pkg::*;
#(
   parameter int p_max = BCD_LO_MAX,
   parameter int p_w   = LO_W
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_en,
   input  logic           i_up,
   input  logic           i_load,
   input  logic [p_w-1:0] i_load_val,
   output logic [p_w-1:0] o_val,
   output logic           o_wrap
);

   assign o_wrap = i_up ? (o_val == p_w'(p_max)) : (o_val == '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_val <= '0;
      end else if (i_load) begin
         o_val <= i_load_val;
      end else if (i_en) begin
         if (i_up) o_val <= o_wrap ? '0 : o_val + p_w'(1);
         else      o_val <= o_wrap ? p_w'(p_max) : o_val - p_w'(1);
      end
   end

endmodule

// File: rtl/bcd_timer_top.sv
// mm:ss (hh:mm:ss with TIMER_HOURS_EN defined) BCD stopwatch / countdown.
//  i_clk, i_reset        : clock, async active-high reset
//  i_start / i_stop      : begin-resume / pause (stop wins when both set)
//  i_load, i_preset_bcd  : preset {hr_hi,hr_lo,min_hi,min_lo,sec_hi,sec_lo}
//  i_mode_up             : 1 = stopwatch, 0 = countdown (latched on start from IDLE)
//  o_sec_lo..o_min_hi    : time digits; o_hr_bcd hours (0 without TIMER_HOURS_EN)
//  o_second_imp          : 1 s tick while running
//  o_minute_imp          : seconds carry/borrow
//  o_done                : countdown reached zero
//  o_running             : state is RUN
//
// state | meaning
// IDLE  | stopped after reset or load; waits for start
// RUN   | prescaler running, digits advance every tick
// PAUSE | stopped by i_stop; prescaler phase retained
// DONE  | countdown hit zero; waits for start or load
module bcd_timer_top
   import timer_pkg::*;
#(
   parameter int p_clk_hz   = 50_000_000,
   parameter int p_hour_max = 23
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic        i_load,
   input  logic        i_mode_up,
   input  logic [23:0] i_preset_bcd,
   output logic [3:0]  o_sec_lo,
   output logic [2:0]  o_sec_hi,
   output logic [3:0]  o_min_lo,
   output logic [2:0]  o_min_hi,
   output logic [7:0]  o_hr_bcd,
   output logic        o_second_imp,
   output logic        o_minute_imp,
   output logic        o_done,
   output logic        o_running
);

   localparam int PRE_W = (p_clk_hz > 1) ? $clog2(p_clk_hz) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(p_clk_hz - 1);

   timer_state_t     state, state_nxt;
   logic             mode_up;
   logic [PRE_W-1:0] presc;
   logic             presc_clr, go, load_ok, tick, cnt_en;
   logic             zero, one_sec, hr_zero, done_tick, start_done;
   logic             w_sec_lo, w_sec_hi, w_min_lo, w_min_hi;
   logic             en_sec_hi, en_min_lo, en_min_hi;

   assign go      = i_start && !i_stop;
   assign load_ok = i_load && (state != RUN);
   assign tick    = (state == RUN) && (presc == PRE_TC);
   // A countdown restarted from DONE sits at zero instead of borrowing to 59:59.
   assign cnt_en  = tick && (mode_up || !zero);

   assign zero    = hr_zero && (o_sec_lo == '0) && (o_sec_hi == '0)
                    && (o_min_lo == '0) && (o_min_hi == '0);
   assign one_sec = hr_zero && (o_sec_lo == 4'd1) && (o_sec_hi == '0)
                    && (o_min_lo == '0) && (o_min_hi == '0);

   // The tick that takes the count from 1 s to zero is the done event.
   assign done_tick  = tick && !mode_up && one_sec;
   assign start_done = (state == IDLE) && !i_load && go && !i_mode_up && zero;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!i_load && go) state_nxt = start_done ? DONE : RUN;
         RUN:   if (done_tick) state_nxt = DONE;
                else if (i_stop) state_nxt = PAUSE;
         PAUSE: if (i_load) state_nxt = IDLE;
                else if (go) state_nxt = RUN;
         DONE:  if (i_load) state_nxt = IDLE;
                else if (go) state_nxt = RUN;
      endcase
      presc_clr = load_ok || ((state == IDLE || state == DONE) && state_nxt == RUN);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         mode_up <= 1'b0;
         presc   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && !i_load && go) mode_up <= i_mode_up;
         if (presc_clr)          presc <= '0;
         else if (state == RUN)  presc <= tick ? '0 : presc + PRE_W'(1);
      end
   end

   assign en_sec_hi = cnt_en && w_sec_lo;
   assign en_min_lo = en_sec_hi && w_sec_hi;
   assign en_min_hi = en_min_lo && w_min_lo;

   bcd_digit_counter #(.p_max(BCD_LO_MAX), .p_w(LO_W)) u_sec_lo (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(cnt_en), .i_up(mode_up), .i_load(load_ok),
      .i_load_val(sat_lo(i_preset_bcd[SEC_LO_OFS +: 4])), .o_val(o_sec_lo), .o_wrap(w_sec_lo));

   bcd_digit_counter #(.p_max(BCD_HI_MAX), .p_w(HI_W)) u_sec_hi (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(en_sec_hi), .i_up(mode_up), .i_load(load_ok),
      .i_load_val(sat_hi(i_preset_bcd[SEC_HI_OFS +: 4])), .o_val(o_sec_hi), .o_wrap(w_sec_hi));

   bcd_digit_counter #(.p_max(BCD_LO_MAX), .p_w(LO_W)) u_min_lo (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(en_min_lo), .i_up(mode_up), .i_load(load_ok),
      .i_load_val(sat_lo(i_preset_bcd[MIN_LO_OFS +: 4])), .o_val(o_min_lo), .o_wrap(w_min_lo));

   bcd_digit_counter #(.p_max(BCD_HI_MAX), .p_w(HI_W)) u_min_hi (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(en_min_hi), .i_up(mode_up), .i_load(load_ok),
      .i_load_val(sat_hi(i_preset_bcd[MIN_HI_OFS +: 4])), .o_val(o_min_hi), .o_wrap(w_min_hi));

`ifdef TIMER_HOURS_EN
   localparam logic [3:0] HR_MAX_HI = 4'(p_hour_max / 10);
   localparam logic [3:0] HR_MAX_LO = 4'(p_hour_max % 10);

   logic [3:0] hr_hi, hr_lo, hr_ld_lo;
   logic [7:0] hr_ld_dec;
   logic       hr_en, hr_wrap;

   // Hours wrap at p_hour_max rather than at a per-digit limit, so both digits live here.
   assign hr_en     = en_min_hi && w_min_hi;
   assign hr_zero   = (hr_hi == '0) && (hr_lo == '0);
   assign hr_wrap   = mode_up ? (hr_hi == HR_MAX_HI && hr_lo == HR_MAX_LO) : hr_zero;
   assign hr_ld_lo  = sat_lo(i_preset_bcd[HR_LO_OFS +: 4]);
   assign hr_ld_dec = 8'(i_preset_bcd[HR_HI_OFS +: 4]) * 8'd10 + 8'(hr_ld_lo);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         hr_hi <= '0;
         hr_lo <= '0;
      end else if (load_ok) begin
         if (hr_ld_dec > 8'(p_hour_max)) begin
            hr_hi <= HR_MAX_HI;
            hr_lo <= HR_MAX_LO;
         end else begin
            hr_hi <= i_preset_bcd[HR_HI_OFS +: 4];
            hr_lo <= hr_ld_lo;
         end
      end else if (hr_en) begin
         if (mode_up) begin
            if (hr_wrap) begin
               hr_hi <= '0;
               hr_lo <= '0;
            end else if (hr_lo == 4'd9) begin
               hr_hi <= hr_hi + 4'd1;
               hr_lo <= '0;
            end else begin
               hr_lo <= hr_lo + 4'd1;
            end
         end else begin
            if (hr_wrap) begin
               hr_hi <= HR_MAX_HI;
               hr_lo <= HR_MAX_LO;
            end else if (hr_lo == '0) begin
               hr_hi <= hr_hi - 4'd1;
               hr_lo <= 4'd9;
            end else begin
               hr_lo <= hr_lo - 4'd1;
            end
         end
      end
   end

   assign o_hr_bcd = {hr_hi, hr_lo};
`else
   localparam int unused_hour_max = p_hour_max;
   logic unused_preset_hr;

   assign unused_preset_hr = ^i_preset_bcd[23:16];
   assign hr_zero          = 1'b1;
   assign o_hr_bcd         = '0;
`endif

   assign o_second_imp = tick;
   assign o_minute_imp = en_min_lo;
   assign o_done       = done_tick || start_done;
   assign o_running    = (state == RUN);

endmodule
